// File: rtl/rr_mux_arbiter_pkg.sv
// Shared arbiter definitions: mode encodings and the channel-index width helper.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_SEL = 1'b1
  } mode_e;

  // Index width never collapses to zero, even for a single channel.
  function automatic int ch_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_grant.sv
// Round-robin picker: first requester at or above ptr, wrapping; purely combinational.
// Latency 0; no backpressure of its own (caller qualifies the grant).
module rr_grant_picker
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] idx
);

  always_comb begin
    logic w_found;
    int   w_c;
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      w_c = (int'(ptr) + k) % N_CH;
      if (!w_found && req[w_c]) begin
        w_found    = 1'b1;
        grant[w_c] = 1'b1;
        idx        = CH_W'(w_c);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 mux with round-robin or manual channel select into a single output register.
// Latency 1 cycle; a stalled output register drops every in_ready, full rate otherwise.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CH_W = ch_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [CH_W-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic [CH_W-1:0]  r_rr_ptr;

  mode_e            w_mode;
  logic [N_CH-1:0]  w_rr_grant;
  logic [CH_W-1:0]  w_rr_idx;
  logic [N_CH-1:0]  w_sel_grant;
  logic [N_CH-1:0]  w_grant;
  logic [CH_W-1:0]  w_gidx;
  logic [WIDTH-1:0] w_gdata;
  logic             w_any;
  logic             w_load;

  assign w_mode = mode_e'(mode);

  rr_grant_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .req   (in_valid),
    .ptr   (r_rr_ptr),
    .grant (w_rr_grant),
    .idx   (w_rr_idx)
  );

  // Manual grant looks only at in_valid[sel]; out-of-range sel matches no channel.
  always_comb begin
    w_sel_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(sel) == i) w_sel_grant[i] = in_valid[i];
    end
  end

  assign w_grant  = (w_mode == MODE_SEL) ? w_sel_grant : w_rr_grant;
  assign w_gidx   = (w_mode == MODE_SEL) ? sel : w_rr_idx;
  assign w_any    = |w_grant;
  assign w_load   = !r_out_valid || out_ready;
  assign in_ready = (rst_n && w_load) ? w_grant : '0;

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gidx == CH_W'(i)) w_gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_data  <= w_gdata;
        r_out_ch    <= w_gidx;
        r_out_valid <= 1'b1;
        if (w_mode == MODE_RR) begin
          r_rr_ptr <= (w_gidx == CH_W'(N_CH-1)) ? '0 : w_gidx + CH_W'(1);
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Vector-table bench for rr_mux_arbiter (N_CH=4, WIDTH=8) with an output-beat scoreboard.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  rr_mux_arbiter #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [7:0] dat;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [7:0] dat;
    logic [1:0] ch;
  } beat_t;

  localparam int NV = 27;
  vec_t  vt [NV];
  beat_t sb [$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic r, input logic [7:0] d);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = d + 8'(i);
  endtask

  // Sample at negedge: compare held beat against scoreboard head, then account for this edge.
  task automatic apply(input vec_t v, input int idx);
    beat_t b;
    drive(v.mode, v.sel, v.vld, v.ordy, v.dat);
    @(negedge clk);
    chk($sformatf("in_ready[v%0d]", idx), 32'(in_ready), 32'(v.exp_rdy));
    chk($sformatf("out_valid[v%0d]", idx), 32'(out_valid), 32'(sb.size() != 0));
    if (out_valid && sb.size() != 0) begin
      chk($sformatf("out_data[v%0d]", idx), 32'(out_data), 32'(sb[0].dat));
      chk($sformatf("out_ch[v%0d]", idx), 32'(out_ch), 32'(sb[0].ch));
      if (out_ready) void'(sb.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      if (v.exp_rdy[i]) begin
        b.ch  = 2'(i);
        b.dat = v.dat + 8'(i);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //            mode sel   vld      ordy dat    exp_rdy
    vt[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h10, 4'b0001};
    vt[1]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h20, 4'b0010};
    vt[2]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h30, 4'b0100};
    vt[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h40, 4'b1000};
    vt[4]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h50, 4'b0001};
    vt[5]  = '{1'b0, 2'd0, 4'b0010, 1'b1, 8'h60, 4'b0010};  // ptr -> 2
    vt[6]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 8'h70, 4'b1000};
    vt[7]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 8'h80, 4'b0010};
    vt[8]  = '{1'b0, 2'd0, 4'b1010, 1'b1, 8'h90, 4'b1000};
    vt[9]  = '{1'b0, 2'd0, 4'b0001, 1'b1, 8'hA5, 4'b0001};  // loads 0xA5
    vt[10] = '{1'b0, 2'd0, 4'b1111, 1'b0, 8'hB0, 4'b0000};
    vt[11] = '{1'b0, 2'd0, 4'b1111, 1'b0, 8'hB0, 4'b0000};
    vt[12] = '{1'b0, 2'd0, 4'b1111, 1'b0, 8'hB0, 4'b0000};
    vt[13] = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'hC0, 4'b0010};  // drain + load
    vt[14] = '{1'b1, 2'd2, 4'b1111, 1'b1, 8'hD0, 4'b0100};
    vt[15] = '{1'b1, 2'd2, 4'b1011, 1'b1, 8'hE0, 4'b0000};
    vt[16] = '{1'b1, 2'd2, 4'b1011, 1'b1, 8'hE0, 4'b0000};
    vt[17] = '{1'b1, 2'd0, 4'b0001, 1'b1, 8'hF0, 4'b0001};
    vt[18] = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h00, 4'b0100};  // ptr untouched by manual
    vt[19] = '{1'b1, 2'd3, 4'b1111, 1'b0, 8'h10, 4'b0000};
    vt[20] = '{1'b1, 2'd3, 4'b1111, 1'b1, 8'h20, 4'b1000};
    vt[21] = '{1'b0, 2'd0, 4'b0000, 1'b1, 8'h30, 4'b0000};
    vt[22] = '{1'b0, 2'd0, 4'b0000, 1'b0, 8'h30, 4'b0000};
    vt[23] = '{1'b0, 2'd0, 4'b1111, 1'b0, 8'h40, 4'b1000};
    vt[24] = '{1'b0, 2'd0, 4'b1111, 1'b1, 8'h50, 4'b0001};
    vt[25] = '{1'b0, 2'd0, 4'b0000, 1'b1, 8'h60, 4'b0000};
    vt[26] = '{1'b0, 2'd0, 4'b0000, 1'b1, 8'h60, 4'b0000};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b1111, 1'b1, 8'h77);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(vt[i], i);

    // Load a beat (ch1 from ptr=1), then reset mid-cycle while it is held.
    drive(1'b0, 2'd0, 4'b1111, 1'b0, 8'h80);
    @(posedge clk);
    #2;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_ch", 32'(out_ch), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 4'b1111, 1'b1, 8'h90);
    @(negedge clk);
    chk("post_rst_grant", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 4'b0000, 1'b1, 8'h90);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_ch", 32'(out_ch), 32'd0);
    chk("post_rst_data", 32'(out_data), 32'h90);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
